// File: rtl/de2i_150_qsys_led_seq.sv
// de2i_150_qsys_led_seq: Avalon-MM LED pattern sequencer for the 4-bit LED port.
// When idle it shows a direct value. When running it steps through a 4-entry
// pattern table, holding each step for a programmable dwell, one-shot or looping.
//
// Optional feature macro: LED_SEQ_PWM_EN. When defined, a 4-bit free-running
// counter dims out_port according to CTRL[11:8] (brightness).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   address[2:0]      register word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[31:0]   write data
//   readdata[31:0]    combinational read data
//   out_port[3:0]     LED drive (registered)
//   irq               level interrupt = done & irq_en (registered)
module de2i_150_qsys_led_seq #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  out_port,
  output logic        irq
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_DIRECT = 3'd3;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [1:0]          cur_q, cur_d;
  logic                done_set_c;

  logic                loop_q, loop_d;
  logic [1:0]          last_q, last_d;
  logic                irq_en_q, irq_en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [3:0]          direct_q, direct_d;
  logic [3:0]          pat_q [4];
  logic [3:0]          pat_d [4];
  logic                done_q, done_d;
  logic [3:0]          sel_c;
  logic [3:0]          out_d;
  logic                irq_d;
  logic                busy_c;
  logic [3:0]          bright_c;

`ifdef LED_SEQ_PWM_EN
  logic [3:0]          bright_q, bright_d;
  logic [3:0]          pwm_q, pwm_d;
`endif

  logic wr_c, ctrl_wr_c, status_wr_c;
  logic [PERIOD_W-1:0] reload_c;
  logic unused_c;

  assign wr_c        = chipselect & ~write_n;
  assign ctrl_wr_c   = wr_c && (address == A_CTRL);
  assign status_wr_c = wr_c && (address == A_STATUS);
  // A programmed period of 0 behaves as a 1-cycle dwell.
  assign reload_c    = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign busy_c      = (state_q == S_RUN);
  assign unused_c    = ^writedata;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // FSM next state: a CTRL write overrides the dwell/step decision
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    done_set_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cur_d = '0;
        if (ctrl_wr_c && writedata[0]) begin
          state_d = S_RUN;
          cnt_d   = reload_c;
        end
      end
      S_RUN: begin
        if (ctrl_wr_c) begin
          cur_d = '0;
          if (writedata[0]) begin
            cnt_d = reload_c;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q <= PERIOD_W'(1)) begin
          if (cur_q != last_q) begin
            cur_d = cur_q + 2'd1;
            cnt_d = reload_c;
          end else if (loop_q) begin
            cur_d = '0;
            cnt_d = reload_c;
          end else begin
            state_d    = S_IDLE;
            cur_d      = '0;
            done_set_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register-file next values
  always_comb begin
    loop_d   = loop_q;
    last_d   = last_q;
    irq_en_d = irq_en_q;
    period_d = period_q;
    direct_d = direct_q;
    pat_d    = pat_q;
`ifdef LED_SEQ_PWM_EN
    bright_d = bright_q;
    pwm_d    = pwm_q + 4'd1;
`endif
    if (ctrl_wr_c) begin
      loop_d   = writedata[1];
      last_d   = writedata[3:2];
      irq_en_d = writedata[4];
`ifdef LED_SEQ_PWM_EN
      bright_d = writedata[11:8];
`endif
    end
    if (wr_c && (address == A_PERIOD)) period_d = writedata[PERIOD_W-1:0];
    if (wr_c && (address == A_DIRECT)) direct_d = writedata[3:0];
    if (wr_c && address[2])            pat_d[address[1:0]] = writedata[3:0];
    // Setting done has priority over a coincident clear.
    done_d = done_set_c | (done_q & ~(status_wr_c & writedata[1]));
  end

  // FSM outputs, computed from next values so the registered port tracks state
  always_comb begin
    sel_c = direct_d;
    if (state_d == S_RUN) sel_c = pat_d[cur_d];
`ifdef LED_SEQ_PWM_EN
    out_d = sel_c & {4{pwm_d <= bright_d}};
`else
    out_d = sel_c;
`endif
    irq_d = done_d & irq_en_d;
  end

  // Register file and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q   <= 1'b0;
      last_q   <= '0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      direct_q <= '0;
      for (int i = 0; i < 4; i++) pat_q[i] <= '0;
      done_q   <= 1'b0;
      out_port <= '0;
      irq      <= 1'b0;
`ifdef LED_SEQ_PWM_EN
      bright_q <= 4'hF;
      pwm_q    <= '0;
`endif
    end else begin
      loop_q   <= loop_d;
      last_q   <= last_d;
      irq_en_q <= irq_en_d;
      period_q <= period_d;
      direct_q <= direct_d;
      pat_q    <= pat_d;
      done_q   <= done_d;
      out_port <= out_d;
      irq      <= irq_d;
`ifdef LED_SEQ_PWM_EN
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
`endif
    end
  end

`ifdef LED_SEQ_PWM_EN
  assign bright_c = bright_q;
`else
  assign bright_c = 4'h0;
`endif

  // Zero-latency read mux; the run bit reads as busy
  always_comb begin
    readdata = '0;
    unique case (address)
      A_CTRL:   readdata = {20'd0, bright_c, 3'd0, irq_en_q, last_q, loop_q, busy_c};
      A_PERIOD: readdata = 32'(period_q);
      A_STATUS: readdata = {26'd0, cur_q, 2'd0, done_q, busy_c};
      A_DIRECT: readdata = {28'd0, direct_q};
      default:  readdata = {28'd0, pat_q[address[1:0]]};
    endcase
  end

endmodule

// File: tb/tb_de2i_150_qsys_led_seq.sv
module tb_de2i_150_qsys_led_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BRW = 32'h0000_0F00;
`ifdef LED_SEQ_PWM_EN
  localparam logic [31:0] BRR = 32'h0000_0F00;
`else
  localparam logic [31:0] BRR = 32'h0;
`endif

  de2i_150_qsys_led_seq #(.PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h req=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic samp(input logic [2:0] a);
    @(negedge clk);
    address = a;
    #1;
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] erd;
    logic [3:0]  eout;
  } vec_t;

  vec_t tbl[$];

  logic [3:0] pats [4];
  logic [3:0] dir;
  int         p, pe, n, lp, ie, last, cyc, idx, s, cnt;
  logic [31:0] act, exp;

  initial begin
    tbl.push_back('{1'b1, 3'd3, 32'h0000_000A, 3'd3, 32'h0000_000A, 4'hA});
    tbl.push_back('{1'b0, 3'd0, 32'h0,         3'd2, 32'h0,         4'hA});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_0003, 3'd1, 32'h0000_0003, 4'hA});
    tbl.push_back('{1'b1, 3'd4, 32'h0000_0001, 3'd4, 32'h0000_0001, 4'hA});
    tbl.push_back('{1'b1, 3'd5, 32'h0000_0002, 3'd5, 32'h0000_0002, 4'hA});
    tbl.push_back('{1'b1, 3'd6, 32'h0000_0004, 3'd6, 32'h0000_0004, 4'hA});
    tbl.push_back('{1'b1, 3'd7, 32'h0000_0008, 3'd7, 32'h0000_0008, 4'hA});
    tbl.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 3'd1, 32'h00FF_FFFF, 4'hA});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_0003, 3'd1, 32'h0000_0003, 4'hA});
    tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFF5, 3'd3, 32'h0000_0005, 4'h5});
    tbl.push_back('{1'b1, 3'd3, 32'h0000_000A, 3'd3, 32'h0000_000A, 4'hA});
    tbl.push_back('{1'b1, 3'd0, BRW | 32'h1C,  3'd0, BRR | 32'h1C,  4'hA});
    tbl.push_back('{1'b1, 3'd2, 32'h0000_00FF, 3'd2, 32'h0,         4'hA});

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(out_port), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("reset_rd%0d", a), readdata, (a == 0) ? BRR : 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven register checks
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].w) wr(tbl[i].wa, tbl[i].wd);
      samp(tbl[i].ra);
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].erd);
      chk($sformatf("tbl%0d_out", i), 32'(out_port), 32'(tbl[i].eout));
    end

    // One-shot 4 steps x 3 cycles with irq
    wr(3'd0, BRW | 32'h1D);
    for (int k = 0; k < 12; k++) begin
      samp(3'd2);
      exp = 32'(4'b0001 << (k / 3));
      chk($sformatf("oneshot_out%0d", k), 32'(out_port), exp);
      chk($sformatf("oneshot_irq%0d", k), 32'(irq), 32'h0);
    end
    samp(3'd2);
    chk("oneshot_end_out", 32'(out_port), 32'hA);
    chk("oneshot_end_status", readdata, 32'h2);
    chk("oneshot_end_irq", 32'(irq), 32'h1);
    samp(3'd0);
    chk("oneshot_run_cleared", readdata, BRR | 32'h1C);
    wr(3'd2, 32'h2);
    samp(3'd2);
    chk("w1c_irq", 32'(irq), 32'h0);
    chk("w1c_status", readdata, 32'h0);

    // Loop with PERIOD=0, two steps, then stop
    wr(3'd1, 32'h0);
    wr(3'd0, BRW | 32'h07);
    for (int k = 0; k < 6; k++) begin
      samp(3'd2);
      chk($sformatf("loop_out%0d", k), 32'(out_port), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    wr(3'd0, BRW);
    samp(3'd2);
    chk("stop_out", 32'(out_port), 32'hA);
    chk("stop_status", readdata, 32'h0);

    // Restart while at step 2
    wr(3'd1, 32'h2);
    wr(3'd0, BRW | 32'h0D);
    repeat (4) @(negedge clk);
    @(negedge clk);
    address = 3'd2;
    #1;
    chk("restart_pre_status", readdata, 32'h21);
    chk("restart_pre_out", 32'(out_port), 32'h4);
    address = 3'd0; writedata = BRW | 32'h0D; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      samp(3'd2);
      chk($sformatf("restart_out%0d", j), 32'(out_port), (j < 2) ? 32'h1 : 32'h2);
    end
    wr(3'd0, BRW);

    // W1C on the same edge that done sets
    wr(3'd1, 32'h1);
    @(negedge clk);
    address = 3'd0; writedata = BRW | 32'h11; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    address = 3'd2; writedata = 32'h2;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    samp(3'd2);
    chk("coinc_status", readdata, 32'h2);
    chk("coinc_irq", 32'(irq), 32'h1);
    chk("coinc_out", 32'(out_port), 32'hA);
    wr(3'd2, 32'h2);
    samp(3'd2);
    chk("coinc_clear", {readdata[30:0], irq}, 32'h0);

`ifdef LED_SEQ_PWM_EN
    wr(3'd3, 32'hF);
    wr(3'd0, 32'h300);
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      samp(3'd2);
      if (out_port == 4'hF) cnt++;
      else if (out_port != 4'h0) cnt += 100;
    end
    chk("pwm_on_count", 32'(cnt), 32'd8);
    wr(3'd0, BRW);
`endif

    // Randomized runs against a timeline model
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++) pats[i] = 4'($urandom_range(0, 15));
      dir  = 4'($urandom_range(0, 15));
      p    = $urandom_range(0, 3);
      last = $urandom_range(0, 3);
      lp   = $urandom_range(0, 1);
      ie   = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) wr(3'(4 + i), 32'(pats[i]));
      wr(3'd3, 32'(dir));
      wr(3'd1, 32'(p));
      wr(3'd0, BRW | 32'(ie << 4) | 32'(last << 2) | 32'(lp << 1) | 32'h1);
      n   = last + 1;
      pe  = (p == 0) ? 1 : p;
      cyc = lp ? (2 * n * pe + 3) : (n * pe + 3);
      for (int k = 0; k < cyc; k++) begin
        samp(3'd2);
        idx = k / pe;
        if (lp != 0 || idx < n) begin
          s   = idx % n;
          exp = {21'd0, pats[s], 1'b0, 2'(s), 2'b00, 1'b0, 1'b1};
        end else begin
          exp = {21'd0, dir, 1'(ie), 6'b000010};
        end
        act = {21'd0, out_port, irq, readdata[5:0]};
        chk($sformatf("rand%0d_k%0d", it, k), act, exp);
      end
      wr(3'd0, BRW);
      wr(3'd2, 32'h2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
